updn_counter_p: RTL

Parametrised successor to the 16-bit up/down load counter: generic width, programmable modulo limit, wrap or saturate mode, synchronous clear, terminal-count pulse and sticky overflow/underflow flags. Used as the general counting primitive in datapath and FIFO-occupancy logic. Ships with an optional embedded SVA checker for reuse in the team's verification flow.

---
 rtl/updn_counter_pkg.sv | 27 ++
 rtl/updn_counter_chk.sv | 95 +++++++++
 rtl/updn_counter_p.sv | 122 ++++++++++++
 3 files changed

// File: rtl/updn_counter_pkg.sv
// updn_counter_pkg: shared types and helpers for the parametrised up/down counter.
//   cnt_op_e  - per-edge operation chosen by the priority decoder
//   decode_op - clr > ld_cnt > count_enb (up/down) > hold
//   DEFAULT_WIDTH - default counter width
package updn_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } cnt_op_e;

  function automatic cnt_op_e decode_op(input logic clr, input logic ld_cnt,
                                        input logic count_enb, input logic updn_cnt);
    cnt_op_e op;
    if (clr)            op = OP_CLR;
    else if (ld_cnt)    op = OP_LOAD;
    else if (count_enb) op = updn_cnt ? OP_UP : OP_DOWN;
    else                op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/updn_counter_chk.sv
// updn_counter_chk: embedded SVA checker for updn_counter_p. Exists only when
// UPDN_COUNTER_ASSERT_EN is defined; otherwise this file contributes no logic.
// Ports: every updn_counter_p port, all as inputs (clk, rst_, clr, ld_cnt, data_in,
//   count_enb, updn_cnt, clr_flags, data_out, tc, ovf, unf).
// Failures are reported with $display and the simulation time.
`ifdef UPDN_COUNTER_ASSERT_EN
module updn_counter_chk
  import updn_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input logic             clk,
  input logic             rst_,
  input logic             clr,
  input logic             ld_cnt,
  input logic [WIDTH-1:0] data_in,
  input logic             count_enb,
  input logic             updn_cnt,
  input logic             clr_flags,
  input logic [WIDTH-1:0] data_out,
  input logic             tc,
  input logic             ovf,
  input logic             unf
);

  localparam logic [WIDTH-1:0] MaxCnt = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  cnt_op_e w_op;
  logic    w_top_evt;
  logic    w_bot_evt;

  assign w_op      = decode_op(clr, ld_cnt, count_enb, updn_cnt);
  assign w_top_evt = (w_op == OP_UP) && (data_out == MaxCnt);
  assign w_bot_evt = (w_op == OP_DOWN) && (data_out == '0);

  a_rst: assert property (@(posedge clk) !rst_ |-> data_out == '0)
    else $display("%0t: updn_counter_chk a_rst failed", $time);
  c_rst: cover property (@(posedge clk) !rst_);

  a_hold: assert property (@(posedge clk) disable iff (!rst_)
    w_op == OP_HOLD |=> data_out == $past(data_out))
    else $display("%0t: updn_counter_chk a_hold failed", $time);
  c_hold: cover property (@(posedge clk) disable iff (!rst_) w_op == OP_HOLD);

  a_clr: assert property (@(posedge clk) disable iff (!rst_)
    w_op == OP_CLR |=> data_out == '0 && !tc)
    else $display("%0t: updn_counter_chk a_clr failed", $time);
  c_clr: cover property (@(posedge clk) disable iff (!rst_) w_op == OP_CLR);

  a_up: assert property (@(posedge clk) disable iff (!rst_)
    (w_op == OP_UP && data_out != MaxCnt) |=> data_out == $past(data_out) + One)
    else $display("%0t: updn_counter_chk a_up failed", $time);
  c_up: cover property (@(posedge clk) disable iff (!rst_) w_op == OP_UP && !w_top_evt);

  a_down: assert property (@(posedge clk) disable iff (!rst_)
    (w_op == OP_DOWN && data_out != '0) |=> data_out == $past(data_out) - One)
    else $display("%0t: updn_counter_chk a_down failed", $time);
  c_down: cover property (@(posedge clk) disable iff (!rst_) w_op == OP_DOWN && !w_bot_evt);

  a_load: assert property (@(posedge clk) disable iff (!rst_)
    w_op == OP_LOAD |=>
      data_out == (($past(data_in) > MaxCnt) ? MaxCnt : $past(data_in)))
    else $display("%0t: updn_counter_chk a_load failed", $time);
  c_load: cover property (@(posedge clk) disable iff (!rst_) w_op == OP_LOAD);

  a_top: assert property (@(posedge clk) disable iff (!rst_)
    w_top_evt |=> data_out == (SATURATE ? MaxCnt : '0) && tc && ovf)
    else $display("%0t: updn_counter_chk a_top failed", $time);
  c_top: cover property (@(posedge clk) disable iff (!rst_) w_top_evt);

  a_bot: assert property (@(posedge clk) disable iff (!rst_)
    w_bot_evt |=> data_out == (SATURATE ? '0 : MaxCnt) && tc && unf)
    else $display("%0t: updn_counter_chk a_bot failed", $time);
  c_bot: cover property (@(posedge clk) disable iff (!rst_) w_bot_evt);

  a_tc_only_evt: assert property (@(posedge clk) disable iff (!rst_)
    !(w_top_evt || w_bot_evt) |=> !tc)
    else $display("%0t: updn_counter_chk a_tc_only_evt failed", $time);
  c_tc_only_evt: cover property (@(posedge clk) disable iff (!rst_) tc ##1 !tc);

  a_ovf_sticky: assert property (@(posedge clk) disable iff (!rst_)
    (ovf && !clr_flags) |=> ovf)
    else $display("%0t: updn_counter_chk a_ovf_sticky failed", $time);
  c_ovf_sticky: cover property (@(posedge clk) disable iff (!rst_) ovf && !clr_flags);

  a_unf_sticky: assert property (@(posedge clk) disable iff (!rst_)
    (unf && !clr_flags) |=> unf)
    else $display("%0t: updn_counter_chk a_unf_sticky failed", $time);
  c_unf_sticky: cover property (@(posedge clk) disable iff (!rst_) unf && !clr_flags);

endmodule
`endif

// File: rtl/updn_counter_p.sv
// updn_counter_p: parametrised up/down counter with load, synchronous clear, modulo
// limit MAX_VAL, wrap or saturate at the boundaries, terminal-count pulse and sticky
// overflow/underflow flags.
// Ports: clk, rst_ (async active-low), clr, ld_cnt, data_in, count_enb, updn_cnt,
//   clr_flags -> data_out (count), tc (boundary pulse), ovf, unf (sticky flags).
// Optional: define UPDN_COUNTER_ASSERT_EN to bind in the updn_counter_chk checker.
module updn_counter_p
  import updn_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr,
  input  logic             ld_cnt,
  input  logic [WIDTH-1:0] data_in,
  input  logic             count_enb,
  input  logic             updn_cnt,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updn_counter_p: WIDTH must lie in 2..32");
  end
  if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("updn_counter_p: MAX_VAL must be below 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxCnt = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  cnt_op_e          w_op;
  logic [WIDTH-1:0] w_cnt_d;
  logic             w_tc_d;
  logic             w_ovf_d;
  logic             w_unf_d;

  assign w_op = decode_op(clr, ld_cnt, count_enb, updn_cnt);

  always_comb begin
    w_cnt_d = r_cnt;
    w_tc_d  = 1'b0;
    // A boundary event below overrides a simultaneous clr_flags.
    w_ovf_d = r_ovf & ~clr_flags;
    w_unf_d = r_unf & ~clr_flags;
    unique case (w_op)
      OP_CLR:  w_cnt_d = '0;
      OP_LOAD: w_cnt_d = (data_in > MaxCnt) ? MaxCnt : data_in;
      OP_UP: begin
        if (r_cnt == MaxCnt) begin
          w_cnt_d = SATURATE ? MaxCnt : '0;
          w_tc_d  = 1'b1;
          w_ovf_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + One;
        end
      end
      OP_DOWN: begin
        if (r_cnt == '0) begin
          w_cnt_d = SATURATE ? '0 : MaxCnt;
          w_tc_d  = 1'b1;
          w_unf_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt - One;
        end
      end
      default: w_cnt_d = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_tc  <= w_tc_d;
      r_ovf <= w_ovf_d;
      r_unf <= w_unf_d;
    end
  end

  assign data_out = r_cnt;
  assign tc       = r_tc;
  assign ovf      = r_ovf;
  assign unf      = r_unf;

`ifdef UPDN_COUNTER_ASSERT_EN
  updn_counter_chk #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_chk (
    .clk       (clk),
    .rst_      (rst_),
    .clr       (clr),
    .ld_cnt    (ld_cnt),
    .data_in   (data_in),
    .count_enb (count_enb),
    .updn_cnt  (updn_cnt),
    .clr_flags (clr_flags),
    .data_out  (data_out),
    .tc        (tc),
    .ovf       (ovf),
    .unf       (unf)
  );
`endif

endmodule
